// File: rtl/shift_normalizer32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_normalizer32_pkg
// Purpose  : Shared constants, FSM encodings and step-size table for the
//            32-bit binary-search normalizer (CLZ / redundant-sign count).
// Revision : 1.0 - initial release
// ============================================================================
package shift_normalizer32_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_CNT_WIDTH  = 5;
    localparam int c_NORM_STEPS = 5;
    localparam int c_K_WIDTH    = 3;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Indexed by the step counter k: k=4 -> 16 ... k=0 -> 1.
    localparam logic [c_NORM_STEPS-1:0][c_CNT_WIDTH-1:0] c_STEP_SIZE =
        {5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

endpackage
`default_nettype wire

// File: rtl/shift_normalizer32_norm_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_normalizer32_norm_step
// Purpose  : One binary-search step: decides whether W may be shifted left by
//            n without losing significance, and returns the resulting word.
//            SHIFT_NORM_SIGNED_EN selects the redundant-sign-bit test.
// Revision : 1.0 - initial release
// ============================================================================
module shift_normalizer32_norm_step #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [CNT_WIDTH-1:0]  i_stepSize,
    output logic                  o_shift,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_back;

    assign w_shifted = i_word << i_stepSize;

    // A shift is safe exactly when shifting back recovers the original word.
`ifdef SHIFT_NORM_SIGNED_EN
    assign w_back = $signed(w_shifted) >>> i_stepSize;
`else
    assign w_back = w_shifted >> i_stepSize;
`endif

    assign o_shift = (w_back == i_word);
    assign o_word  = o_shift ? w_shifted : i_word;

endmodule
`default_nettype wire

// File: rtl/shift_normalizer32.sv
`default_nettype none
// ============================================================================
// Module   : shift_normalizer32
// Purpose  : Multi-cycle normalizer returning shift count S and normalized
//            word Y in a fixed 5-step binary search (16/8/4/2/1).
//            Build option SHIFT_NORM_SIGNED_EN: count redundant sign bits.
// Revision : 1.0 - initial release
// ============================================================================
module shift_normalizer32
    import shift_normalizer32_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int CNT_WIDTH  = c_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] D,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] Y,
    output logic [CNT_WIDTH-1:0]  S,
    output logic                  ZERO
);

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_work;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [c_K_WIDTH-1:0]  r_k;

    logic [CNT_WIDTH-1:0]  w_stepSize;
    logic                  w_doShift;
    logic [DATA_WIDTH-1:0] w_nextWork;
    logic [CNT_WIDTH-1:0]  w_nextCnt;
    logic                  w_nextZero;

    assign w_stepSize = c_STEP_SIZE[r_k];

    shift_normalizer32_norm_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_normStep (
        .i_word     (r_work),
        .i_stepSize (w_stepSize),
        .o_shift    (w_doShift),
        .o_word     (w_nextWork)
    );

    assign w_nextCnt = w_doShift ? (r_cnt + w_stepSize) : r_cnt;

    // In the signed build both all-zeros and all-ones saturate the count.
`ifdef SHIFT_NORM_SIGNED_EN
    assign w_nextZero = (w_nextCnt == {CNT_WIDTH{1'b1}});
`else
    assign w_nextZero = (w_nextWork == '0);
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            Y       <= '0;
            S       <= '0;
            ZERO    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (START) begin
                        r_work  <= D;
                        r_cnt   <= '0;
                        r_k     <= c_K_WIDTH'(c_NORM_STEPS - 1);
                        BUSY    <= 1'b1;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_work <= w_nextWork;
                    r_cnt  <= w_nextCnt;
                    if (r_k == '0) begin
                        Y       <= w_nextWork;
                        S       <= w_nextCnt;
                        ZERO    <= w_nextZero;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer32.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_normalizer32
// Purpose  : Self-checking bench for shift_normalizer32 against a bit-scan
//            reference model (SHIFT_NORM_SIGNED_EN selects signed model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_normalizer32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [31:0] D = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] Y;
    logic [4:0]  S;
    logic        ZERO;

    int nCompared = 0;
    int nMismatched = 0;

    shift_normalizer32 dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .D     (D),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Y     (Y),
        .S     (S),
        .ZERO  (ZERO)
    );

    always #5 CLK = ~CLK;

    // Reference: scan bits from the top and count insignificant ones.
    function automatic void refModel(input logic [31:0] d, output logic [4:0] s,
                                     output logic [31:0] y, output logic z);
        int  cnt = 0;
        bit  stop = 0;
`ifdef SHIFT_NORM_SIGNED_EN
        for (int i = 30; i >= 0; i--) begin
            if (!stop && d[i] == d[31]) cnt++;
            else stop = 1;
        end
        z = (d == 32'h0) || (d == 32'hFFFF_FFFF);
`else
        for (int i = 31; i >= 0; i--) begin
            if (!stop && !d[i]) cnt++;
            else stop = 1;
        end
        if (cnt > 31) cnt = 31;
        z = (d == 32'h0);
`endif
        s = cnt[4:0];
        y = d << cnt;
    endfunction

    // Drive one request; returns cycles from accepting edge to DONE (-1 on timeout).
    task automatic doOp(input logic [31:0] d, output int lat);
        @(negedge CLK);
        START = 1'b1;
        D = d;
        @(posedge CLK);
        #1;
        START = 1'b0;
        D = $urandom;
        lat = 0;
        while (!DONE && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (!DONE) lat = -1;
    endtask

    task automatic checkResult(input string name, input logic [31:0] d, input int lat);
        logic [4:0]  eS;
        logic [31:0] eY;
        logic        eZ;
        refModel(d, eS, eY, eZ);
        nCompared++;
        if (lat !== 5 || S !== eS || Y !== eY || ZERO !== eZ) begin
            nMismatched++;
            $display("FAIL %s d=%h: got lat=%0d S=%0d Y=%h Z=%b, want lat=5 S=%0d Y=%h Z=%b",
                     name, d, lat, S, Y, ZERO, eS, eY, eZ);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        nCompared++;
        if ({BUSY, DONE, ZERO} !== 3'b000 || Y !== 32'h0 || S !== 5'd0) begin
            nMismatched++;
            $display("FAIL reset: got BUSY=%b DONE=%b ZERO=%b Y=%h S=%0d, want all 0",
                     BUSY, DONE, ZERO, Y, S);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] vec [5];
        int lat;
`ifdef SHIFT_NORM_SIGNED_EN
        vec = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
`else
        vec = '{32'h0000_0001, 32'h8000_0000, 32'h00F0_0000, 32'h0000_0000, 32'h0000_0001};
`endif
        foreach (vec[i]) begin
            doOp(vec[i], lat);
            checkResult("directed", vec[i], lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int lat;
        for (int i = 0; i < 40; i++) begin
            d = $urandom >> $urandom_range(0, 31);
`ifdef SHIFT_NORM_SIGNED_EN
            if ($urandom_range(0, 1) == 1) d = ~d;
`endif
            doOp(d, lat);
            checkResult("random", d, lat);
        end
    endtask

    task automatic test_start_held();
        logic [31:0] d0;
        logic [31:0] prevY;
        int lat;
        int busyLow;
        d0 = 32'h0003_1234;
        prevY = Y;
        @(negedge CLK);
        START = 1'b1;
        D = d0;
        @(posedge CLK);
        #1;
        nCompared++;
        if (Y !== prevY || BUSY !== 1'b1) begin
            nMismatched++;
            $display("FAIL start_hold_y: got Y=%h BUSY=%b, want Y=%h BUSY=1", Y, BUSY, prevY);
        end
        lat = 0;
        busyLow = 0;
        while (!DONE && lat < 20) begin
            @(negedge CLK);
            D = $urandom;
            @(posedge CLK);
            #1;
            lat++;
            if (!DONE && !BUSY) busyLow++;
        end
        @(negedge CLK);
        START = 1'b0;
        if (!DONE) lat = -1;
        checkResult("start_held", d0, lat);
        nCompared++;
        if (busyLow !== 0) begin
            nMismatched++;
            $display("FAIL busy_during_run: got %0d low cycles, want 0", busyLow);
        end
        repeat (8) @(posedge CLK);
        #1;
        nCompared++;
        if (BUSY !== 1'b0) begin
            nMismatched++;
            $display("FAIL start_held_idle: got BUSY=%b, want 0", BUSY);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1;
        logic [31:0] d2;
        int lat;
        d1 = 32'h0000_0F00;
        d2 = 32'h0123_4567;
        doOp(d1, lat);
        checkResult("b2b_first", d1, lat);
        // doOp raises START in the DONE cycle, so this is accepted with no gap.
        doOp(d2, lat);
        checkResult("b2b_second", d2, lat);
    endtask

    task automatic test_reset_midrun();
        int doneSeen = 0;
        int lat;
        @(negedge CLK);
        START = 1'b1;
        D = 32'h0000_00FF;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        nCompared++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || Y !== 32'h0 || S !== 5'd0) begin
            nMismatched++;
            $display("FAIL midrun_reset: got BUSY=%b DONE=%b Y=%h S=%0d, want 0 0 0 0",
                     BUSY, DONE, Y, S);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) doneSeen++;
        end
        nCompared++;
        if (doneSeen !== 0) begin
            nMismatched++;
            $display("FAIL aborted_done: got %0d pulses, want 0", doneSeen);
        end
        doOp(32'h0040_0000, lat);
        checkResult("after_reset", 32'h0040_0000, lat);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
